// File: rtl/peripheral_bin2bcd_if.sv
// CPU data-bus slice seen by the bin-to-BCD peripheral: write data, strobes,
// byte offset and registered read data.
interface peripheral_bin2bcd_if #(
  parameter int BIN_W = 16
);
  logic [BIN_W-1:0] d_in;
  logic             cs;
  logic [4:0]       addr;
  logic             rd;
  logic             wr;
  logic [31:0]      d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/peripheral_bin2bcd.sv
// Memory-mapped 16-bit binary to 5-digit packed BCD converter using a
// one-bit-per-clock shift-and-add-3 engine.
module peripheral_bin2bcd #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  peripheral_bin2bcd_if.slave bus
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_START  = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [BIN_W-1:0] a_q;
  logic [SR_W-1:0]  sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BCD_W-1:0] result_q;
  logic             done_q;
  logic             busy_q;
  logic [31:0]      d_out_q;

  logic             wr_en;
  logic             rd_en;
  logic             wr_a;
  logic             start_en;
  logic [BIN_W-1:0] load_d;
  logic [SR_W-1:0]  adj_d;
  logic [SR_W-1:0]  shift_d;

  assign wr_en    = bus.cs & bus.wr;
  assign rd_en    = bus.cs & bus.rd;
  assign wr_a     = wr_en & (bus.addr == ADDR_A);
  assign start_en = wr_en & (bus.addr == ADDR_START) & bus.d_in[0];
  // A value written on the launching edge takes precedence over the stored one
  assign load_d   = wr_a ? bus.d_in : a_q;

  always_comb begin
    adj_d = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5)
        adj_d[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
    end
    shift_d = {adj_d[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      d_out_q  <= '0;
    end else begin
      if (wr_a)
        a_q <= bus.d_in;

      if (rd_en) begin
        case (bus.addr)
          ADDR_STATUS: d_out_q <= {30'b0, busy_q, done_q};
          ADDR_RESULT: d_out_q <= {{(32-BCD_W){1'b0}}, result_q};
          default:     d_out_q <= '0;
        endcase
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_en) begin
            sr_q    <= {{BCD_W{1'b0}}, load_d};
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_q  <= shift_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            result_q <= shift_d[SR_W-1 -: BCD_W];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// Directed bench for peripheral_bin2bcd: register map, conversion latency,
// ignored strobes, mid-conversion reset and back-to-back conversions.
module tb_peripheral_bin2bcd;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  peripheral_bin2bcd_if #(.BIN_W(16)) bus ();

  peripheral_bin2bcd #(.BIN_W(16), .BCD_DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 5'h00; bus.d_in = 16'h0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d, input logic c);
    @(negedge clk);
    bus.cs = c; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(negedge clk);
    bus_idle();
    d = bus.d_out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    bus_idle();
    #1;
    total++;
    if (bus.d_out !== 32'h0) begin
      bad++; $display("FAIL reset_dout actual=%h required=%h", bus.d_out, 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(5'h0C, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_status actual=%h required=%h", v, 32'h0); end
    bus_read(5'h10, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_result actual=%h required=%h", v, 32'h0); end
  endtask

  // Writes A and START, then holds a STATUS read: 16 busy samples, then done.
  task automatic test_convert(input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] v;
    int nbusy;
    bus_write(5'h04, a, 1'b1);
    bus_write(5'h08, 16'h1, 1'b1);
    nbusy = 0;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 5'h0C;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.d_out === 32'h2) nbusy++;
    end
    @(negedge clk);
    v = bus.d_out;
    bus_idle();
    total++;
    if (nbusy != 16) begin bad++; $display("FAIL busy_cycles a=%h actual=%0d required=16", a, nbusy); end
    total++;
    if (v !== 32'h1) begin bad++; $display("FAIL done_status a=%h actual=%h required=%h", a, v, 32'h1); end
    bus_read(5'h10, v);
    total++;
    if (v !== exp) begin bad++; $display("FAIL result a=%h actual=%h required=%h", a, v, exp); end
  endtask

  // START at cycle 5 is ignored; A written at cycle 8 does not disturb the run.
  task automatic test_start_while_busy();
    logic [31:0] v;
    int nbad;
    bus_write(5'h04, 16'h270F, 1'b1);
    bus_write(5'h08, 16'h1, 1'b1);
    nbad = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 5) begin
        bus.cs = 1'b1; bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = 5'h08; bus.d_in = 16'h1;
      end else if (k == 8) begin
        bus.cs = 1'b1; bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = 5'h04; bus.d_in = 16'h0001;
      end else begin
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 5'h0C;
      end
      @(negedge clk);
      if (k <= 16 && bus.d_out !== 32'h2) nbad++;
      if (k == 17 && bus.d_out !== 32'h1) nbad++;
    end
    bus_idle();
    total++;
    if (nbad != 0) begin bad++; $display("FAIL restart_ignored_status bad_samples=%0d required=0", nbad); end
    bus_read(5'h10, v);
    total++;
    if (v !== 32'h00009999) begin bad++; $display("FAIL restart_ignored_result actual=%h required=%h", v, 32'h00009999); end
    // A now holds the value written mid-run
    bus_write(5'h08, 16'h1, 1'b1);
    repeat (18) @(negedge clk);
    bus_read(5'h10, v);
    total++;
    if (v !== 32'h00000001) begin bad++; $display("FAIL write_a_busy actual=%h required=%h", v, 32'h00000001); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bus_write(5'h04, 16'h3039, 1'b1);
    bus_write(5'h08, 16'h1, 1'b1);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 5'h0C;
    repeat (8) @(negedge clk);
    total++;
    if (bus.d_out !== 32'h2) begin bad++; $display("FAIL mid_busy actual=%h required=%h", bus.d_out, 32'h2); end
    reset = 1'b1;
    #1;
    total++;
    if (bus.d_out !== 32'h0) begin bad++; $display("FAIL mid_reset_dout actual=%h required=%h", bus.d_out, 32'h0); end
    bus_idle();
    @(negedge clk);
    reset = 1'b0;
    bus_read(5'h0C, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL mid_reset_status actual=%h required=%h", v, 32'h0); end
    bus_read(5'h10, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL mid_reset_result actual=%h required=%h", v, 32'h0); end
    test_convert(16'h3039, 32'h00012345);
  endtask

  task automatic test_offsets();
    logic [31:0] v;
    logic [4:0] offs [3];
    offs[0] = 5'h00; offs[1] = 5'h14; offs[2] = 5'h1C;
    for (int i = 0; i < 3; i++) begin
      bus_read(5'h10, v);
      bus_read(offs[i], v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL offset_%h actual=%h required=%h", offs[i], v, 32'h0); end
    end
    bus_read(5'h04, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL read_a actual=%h required=%h", v, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int nbad;
    bus_write(5'h04, 16'h0063, 1'b1);
    bus_write(5'h08, 16'h1, 1'b1);
    nbad = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) begin
        bus.cs = 1'b1; bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = 5'h04; bus.d_in = 16'h0400;
      end else begin
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 5'h0C;
      end
      @(negedge clk);
      if (bus.d_out !== 32'h2) nbad++;
    end
    // done has just risen; launch the next conversion on the following edge
    bus.cs = 1'b1; bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = 5'h08; bus.d_in = 16'h1;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j == 8) begin
        total++;
        if (bus.d_out !== 32'h00000099) begin
          bad++; $display("FAIL b2b_first_result actual=%h required=%h", bus.d_out, 32'h00000099);
        end
      end else if (j > 1 && j <= 17) begin
        if (bus.d_out !== 32'h2) nbad++;
      end
      bus.wr = 1'b0; bus.rd = 1'b1; bus.cs = 1'b1;
      bus.addr = (j == 7) ? 5'h10 : 5'h0C;
    end
    @(negedge clk);
    v = bus.d_out;
    bus_idle();
    total++;
    if (nbad != 0) begin bad++; $display("FAIL b2b_busy bad_samples=%0d required=0", nbad); end
    total++;
    if (v !== 32'h1) begin bad++; $display("FAIL b2b_done actual=%h required=%h", v, 32'h1); end
    bus_read(5'h10, v);
    total++;
    if (v !== 32'h00001024) begin bad++; $display("FAIL b2b_result actual=%h required=%h", v, 32'h00001024); end
  endtask

  task automatic test_cs0_and_nostart();
    logic [31:0] v;
    bus_write(5'h04, 16'h1111, 1'b0);
    bus_write(5'h08, 16'h1, 1'b1);
    repeat (18) @(negedge clk);
    bus_read(5'h10, v);
    total++;
    if (v !== 32'h00001024) begin bad++; $display("FAIL cs0_write actual=%h required=%h", v, 32'h00001024); end
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b1; bus.addr = 5'h0C;
    @(negedge clk);
    bus_idle();
    total++;
    if (bus.d_out !== 32'h00001024) begin
      bad++; $display("FAIL cs0_read_hold actual=%h required=%h", bus.d_out, 32'h00001024);
    end
    bus_write(5'h08, 16'h2, 1'b1);
    bus_read(5'h0C, v);
    total++;
    if (v !== 32'h1) begin bad++; $display("FAIL start_bit0_zero actual=%h required=%h", v, 32'h1); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_convert(16'h04D2, 32'h00001234);
    test_convert(16'hFFFF, 32'h00065535);
    test_convert(16'h0000, 32'h00000000);
    test_convert(16'h0009, 32'h00000009);
    test_start_while_busy();
    test_reset_mid();
    test_offsets();
    test_back_to_back();
    test_cs0_and_nostart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
